lsu_seq: RTL

Multi-cycle load/store sequencer between the core's memory stage and a handshaked data memory. It accepts one load/store per request and splits misaligned halfword/word accesses into two word-aligned memory transactions. It generates byte strobes and lane-shifted store data, and merges and sign/zero-extends load data per funct3. It replaces the single-cycle load-extend path when the data memory has wait states.

---
 rtl/lsu_seq_pkg.sv | 27 ++
 rtl/lsu_seq_load_ext.sv | 21 ++
 rtl/lsu_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lsu_seq_pkg.sv
// lsu_seq_pkg: shared encodings, FSM states and size masks for the load/store sequencer
package lsu_seq_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] SZ_B = 4'h1;
    localparam logic [3:0] SZ_H = 4'h3;
    localparam logic [3:0] SZ_W = 4'hf;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    // funct3[1:0] carries the access size for every legal op
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        return sz == 2'b00 ? SZ_B : sz == 2'b01 ? SZ_H : SZ_W;
    endfunction

    function automatic logic legal_op(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                  : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    endfunction
endpackage

// File: rtl/lsu_seq_load_ext.sv
// lsu_load_ext: merge two memory words, shift to the access offset and extend per funct3
module lsu_load_ext
    import lsu_seq_pkg::*;
(
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);
    logic [31:0] m;

    // word1 supplies the upper bytes of an access that crosses a word boundary
    always_comb begin
        m = 32'({word1, word0} >> {off, 3'b000});
        rdata = funct3 == F3_LB  ? {{24{m[7]}}, m[7:0]} :
                funct3 == F3_LH  ? {{16{m[15]}}, m[15:0]} :
                funct3 == F3_LBU ? {24'h0, m[7:0]} :
                funct3 == F3_LHU ? {16'h0, m[15:0]} : m;
    end
endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: multi-cycle load/store sequencer splitting misaligned accesses into two word beats
module lsu_seq
    import lsu_seq_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] word0;
    logic        c_we;
    logic [2:0]  c_f3;
    logic [1:0]  c_off;
    logic [31:0] c_wdata;
    logic [7:0]  lanes;
    logic [63:0] lane_data;
    logic        misal;
    logic        bad;
    logic        split;
    logic [31:0] ld_word0;
    logic [31:0] ld_word1;
    logic [31:0] ld_data;

    assign busy = state != IDLE;

    // In IDLE decode the incoming request, otherwise the latched one; lanes span two words
    always_comb begin
        c_we = state == IDLE ? we : we_q;
        c_f3 = state == IDLE ? funct3 : f3_q;
        c_off = state == IDLE ? addr[1:0] : off_q;
        c_wdata = state == IDLE ? wdata : wdata_q;
        lanes = {4'h0, size_mask(c_f3[1:0])} << c_off;
        lane_data = {32'h0, c_wdata} << {c_off, 3'b000};
        misal = (c_f3[1:0] == 2'b01 && c_off == 2'b11) || (c_f3[1:0] == 2'b10 && c_off != 2'b00);
        bad = !legal_op(c_we, c_f3) || (misal && !MISALIGN_EN);
        split = misal && MISALIGN_EN;
        ld_word0 = state == ACC0 ? mem_rdata : word0;
        ld_word1 = state == ACC1 ? mem_rdata : 32'h0;
    end

    lsu_load_ext u_ext (
        .word0  (ld_word0),
        .word1  (ld_word1),
        .off    (off_q),
        .funct3 (f3_q),
        .rdata  (ld_data)
    );

    // Sequencer FSM; every output is registered and mem_* only change on accept or ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            we_q <= 1'b0;
            f3_q <= 3'h0;
            off_q <= 2'h0;
            wdata_q <= 32'h0;
            word0 <= 32'h0;
            done <= 1'b0;
            err <= 1'b0;
            rdata <= 32'h0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q <= we;
                    f3_q <= funct3;
                    off_q <= addr[1:0];
                    wdata_q <= wdata;
                    if (bad) begin
                        state <= RESP;
                        done <= 1'b1;
                        err <= 1'b1;
                        rdata <= we ? rdata : 32'h0;
                    end else begin
                        state <= ACC0;
                        mem_req <= 1'b1;
                        mem_we <= we;
                        mem_addr <= {addr[31:2], 2'b00};
                        mem_wstrb <= we ? lanes[3:0] : 4'h0;
                        mem_wdata <= lane_data[31:0];
                    end
                end
                ACC0: if (mem_ack) begin
                    word0 <= mem_rdata;
                    if (split) begin
                        state <= ACC1;
                        mem_addr <= mem_addr + 32'd4;
                        mem_wstrb <= we_q ? lanes[7:4] : 4'h0;
                        mem_wdata <= lane_data[63:32];
                    end else begin
                        state <= RESP;
                        mem_req <= 1'b0;
                        done <= 1'b1;
                        err <= 1'b0;
                        rdata <= we_q ? rdata : ld_data;
                    end
                end
                ACC1: if (mem_ack) begin
                    state <= RESP;
                    mem_req <= 1'b0;
                    done <= 1'b1;
                    err <= 1'b0;
                    rdata <= we_q ? rdata : ld_data;
                end
                RESP: begin
                    state <= IDLE;
                    done <= 1'b0;
                    err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
